// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and frame constants for the serial receiver and its companion transmitter
package serial_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} rx_state_t;

  localparam int FRAME_DATA_BITS = 8;

  // Last sample-counter value of the half-bit wait that centres sampling in each bit
  function automatic int half_bit_last(input int clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

endpackage

// File: rtl/bit_sync2.sv
// bit_sync2: two-flop synchroniser for a single asynchronous bit, with a selectable reset value
module bit_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  // Shift the raw input through two flops so q_o is safe to use in the clk_i domain
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ff_q <= {2{RST_VAL}};
    else ff_q <= {ff_q[0], d_i};

  assign q_o = ff_q[1];

endmodule

// File: rtl/serial_char_receiver.sv
// serial_char_receiver: 8N1 serial receiver feeding the Nios parallel-output and char-received PIOs; define SERIAL_RX_PARITY_EN to add an even-parity bit and the parity_error output
module serial_char_receiver
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = FRAME_DATA_BITS
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              serial_in,
  output logic [DATA_W-1:0] parallel_out,
  output logic              char_received,
  output logic              framing_error,
`ifdef SERIAL_RX_PARITY_EN
  output logic              parity_error,
`endif
  output logic              busy
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1  = CW'(half_bit_last(CLKS_PER_BIT));
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_W - 1);
`ifdef SERIAL_RX_PARITY_EN
  localparam rx_state_t     AFTER_DATA = PARITY;
`else
  localparam rx_state_t     AFTER_DATA = STOP;
`endif

  rx_state_t         state_q;
  logic [CW-1:0]     smp_q;
  logic [2:0]        bit_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic              rdy_q;
  logic              ferr_q;
  logic              perr_q;
  logic              rx_s;
  logic              smp_done;

  bit_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_clk),
    .rst_ni(reset_reset_n),
    .d_i   (serial_in),
    .q_o   (rx_s)
  );

  assign smp_done = (state_q == START) ? (smp_q == HALF_M1) : (smp_q == FULL_M1);

  // Frame FSM: detect start, sample each bit at its centre, latch the byte and status flags at the stop bit
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      state_q <= IDLE;
      smp_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      smp_q <= (state_q == IDLE || smp_done) ? '0 : smp_q + CW'(1);
      case (state_q)
        IDLE: if (!rx_s) begin
          state_q <= START;
          rdy_q   <= 1'b0;
          ferr_q  <= 1'b0;
          perr_q  <= 1'b0;
        end
        START: if (smp_done) begin
          bit_q   <= '0;
          state_q <= rx_s ? IDLE : DATA;
        end
        DATA: if (smp_done) begin
          shift_q <= {rx_s, shift_q[DATA_W-1:1]};
          bit_q   <= bit_q + 3'd1;
          if (bit_q == LAST_BIT) state_q <= AFTER_DATA;
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: if (smp_done) begin
          perr_q  <= rx_s ^ (^shift_q);
          state_q <= STOP;
        end
`endif
        STOP: if (smp_done) begin
          ferr_q  <= !rx_s;
          state_q <= IDLE;
          if (rx_s && !perr_q) begin
            data_q <= shift_q;
            rdy_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end

  assign parallel_out  = data_q;
  assign char_received = rdy_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != IDLE);
`ifdef SERIAL_RX_PARITY_EN
  assign parity_error  = perr_q;
`endif

endmodule

// File: tb/tb_serial_char_receiver.sv
// tb_serial_char_receiver: randomized and directed frames checked every cycle against a timing-level frame model
module tb_serial_char_receiver;

  localparam int N = 16;
  localparam int H = N / 2;
`ifdef SERIAL_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT = 3 + H + (9 + PB) * N;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] po;
  logic       cr, fe, bsy, pe;
  int         total = 0;
  int         bad = 0;

  serial_char_receiver #(.CLKS_PER_BIT(N)) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .serial_in    (rx),
    .parallel_out (po),
    .char_received(cr),
    .framing_error(fe),
`ifdef SERIAL_RX_PARITY_EN
    .parity_error (pe),
`endif
    .busy         (bsy)
  );
`ifndef SERIAL_RX_PARITY_EN
  assign pe = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: line history delayed two edges, frame timing measured from the detecting edge
  logic       hist[$];
  logic [7:0] m_po, m_sh;
  logic       m_cr, m_fe, m_pe, m_idle, r;
  int         k, s_edge, t, b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_po = 8'h00; m_cr = 0; m_fe = 0; m_pe = 0; m_idle = 1; m_sh = 8'h00;
      hist = {1'b1, 1'b1};
      k = 0; s_edge = 0;
    end else begin
      hist.push_back(rx);
      r = hist.pop_front();
      k++;
      if (m_idle) begin
        if (!r) begin
          m_idle = 0; s_edge = k; m_cr = 0; m_fe = 0; m_pe = 0;
        end
      end else begin
        t = k - s_edge;
        if (t == H && r) m_idle = 1;
        else if (t > H && (t - H) % N == 0) begin
          b = (t - H) / N;
          if (b <= 8) m_sh[b-1] = r;
          else if (b == 9 && PB == 1) m_pe = r ^ (^m_sh);
          else begin
            m_fe = !r;
            if (r && !m_pe) begin
              m_po = m_sh; m_cr = 1;
            end
            m_idle = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("po", po, m_po);
    chk("cr", cr, m_cr);
    chk("fe", fe, m_fe);
    chk("pe", pe, m_pe);
    chk("busy", bsy, !m_idle);
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic par_ok);
    drive(1'b0, N);
    for (int i = 0; i < 8; i++) drive(d[i], N);
    if (PB == 1) drive((^d) ^ !par_ok, N);
    drive(stop, N);
    rx = 1'b1;
  endtask

  task automatic watch(output int lat, output logic [7:0] p, output logic c, output logic f);
    lat = -1;
    for (int i = 1; i <= LAT + 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i > 3 && (cr || fe || pe)) begin
        lat = i;
        break;
      end
    end
    p = po; c = cr; f = fe;
  endtask

  task automatic frame(input string nm, input logic [7:0] d, input logic stop,
                       input logic [7:0] e_po, input logic e_cr, input logic e_fe);
    int lat;
    logic [7:0] p;
    logic c, f;
    fork
      send(d, stop, 1'b1);
      watch(lat, p, c, f);
    join
    chk({nm, " latency"}, lat, LAT);
    chk({nm, " po"}, p, e_po);
    chk({nm, " cr"}, c, e_cr);
    chk({nm, " fe"}, f, e_fe);
  endtask

  initial begin
    int n;
    logic [7:0] d;
    #1 rst_n = 1'b0;
    #2;
    chk("rst po", po, 8'h00);
    chk("rst cr", cr, 0);
    chk("rst fe", fe, 0);
    chk("rst busy", bsy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 5);

    frame("a5", 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0);
    drive(1'b1, 5);
    frame("55 badstop", 8'h55, 1'b0, 8'hA5, 1'b0, 1'b1);
    drive(1'b1, 2 * N);
    frame("3c", 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0);
    frame("c3 b2b", 8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0);

    drive(1'b0, 4);
    rx = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bsy) n++;
    end
    chk("glitch busy short", (n >= 1 && n <= 10), 1);
    chk("glitch idle", bsy, 0);
    chk("glitch po", po, 8'hC3);
    @(posedge clk); #1;

    drive(1'b0, N);
    for (int i = 0; i < 4; i++) drive(1'b1, N);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst po", po, 8'h00);
    chk("async rst cr", cr, 0);
    chk("async rst fe", fe, 0);
    chk("async rst busy", bsy, 0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 5);
    frame("81", 8'h81, 1'b1, 8'h81, 1'b1, 1'b0);
    drive(1'b1, 3);

`ifdef SERIAL_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0);
    @(negedge clk);
    chk("07 badpar pe", pe, 1);
    chk("07 badpar cr", cr, 0);
    chk("07 badpar po", po, 8'h81);
    @(posedge clk); #1;
    frame("07 par", 8'h07, 1'b1, 8'h07, 1'b1, 1'b0);
    drive(1'b1, 3);
`endif

    for (int it = 0; it < 40; it++) begin
      d = 8'($urandom);
      case ($urandom % 8)
        0: begin
          drive(1'b0, $urandom_range(1, 6));
          drive(1'b1, 14);
        end
        1: begin
          send(d, 1'b0, 1'b1);
          drive(1'b1, 2 * N);
        end
        default: begin
          send(d, 1'b1, ($urandom % 4) != 0);
          if ($urandom % 3 != 0) drive(1'b1, $urandom_range(1, 30));
        end
      endcase
    end
    drive(1'b1, 3 * N);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_char_receiver.md
Name: serial_char_receiver

Overview:
- Asynchronous serial receiver that feeds the Nios system's parallel input PIO and character-received flag.
- Deserialises 8N1 frames (start bit 0, 8 data bits LSB-first, stop bit 1) from a single serial line using a mid-bit sampling counter.
- Presents each received byte and a polled status level to software.
- Sits directly upstream of the Nios PIOs `parallel_output_external_connection_export` and `char_received_external_connection_export`.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit period; must be even and ≥4.
- DATA_W, 8, data bits per frame; fixed at 8 for the PIO width.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- serial_in  in  1  raw serial line; idle high; asynchronous to clk_clk.
- parallel_out  out  8  last correctly framed byte; connects to the Nios parallel_output PIO.
- char_received  out  1  level: a new byte is valid and no new frame has started.
- framing_error  out  1  level: the last frame's stop bit sampled low.
- busy  out  1  high while the state machine is not IDLE.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE; parallel_out=8'h00; char_received=0; framing_error=0; busy=0.
  - Synchroniser flops = 1; bit counter and sample counter = 0.
- Input synchroniser:
  - 2-FF synchroniser on serial_in, producing rx_s.
  - rx_s lags serial_in by 2 clocks.
- States: IDLE, START, DATA, STOP; busy = (state != IDLE).
- IDLE:
  - If rx_s==0: go to START, clear sample counter, clear char_received and framing_error.
- START:
  - Count to CLKS_PER_BIT/2-1, then sample rx_s.
  - If rx_s==1 (glitch): return to IDLE; no flags set.
  - If rx_s==0: go to DATA, clear sample counter and bit counter.
- DATA:
  - Count to CLKS_PER_BIT-1, then shift rx_s into bit [7] of the shift register (right shift, so LSB-first arrival ends LSB-aligned).
  - Increment bit counter and clear sample counter.
  - After the 8th bit, go to STOP.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rx_s.
  - rx_s==1: parallel_out<=shift register; char_received<=1; framing_error<=0.
  - rx_s==0: parallel_out unchanged; char_received stays 0; framing_error<=1.
  - Go to IDLE in both cases.
- Latency:
  - char_received rises exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks after the serial_in falling edge.
  - With CLKS_PER_BIT=16: 155 clocks.
- Persistence: char_received and framing_error are levels that hold until the next start-bit detection, so software polling cannot miss them.
- Break condition (line held low through the stop bit):
  - framing_error is set and the FSM returns to IDLE.
  - IDLE sees rx_s==0 immediately and re-enters START; that frame then fails the glitch check only if the line has returned high.
- Back-to-back frames:
  - A new start bit arriving in the cycle after the STOP sample is accepted.
  - Latching in STOP has priority over the flag-clear in IDLE, so no overlap occurs.
- Counter widths: $clog2(CLKS_PER_BIT) bits; the bit counter is 3 bits. There is no wrap-around beyond the compare values.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- When defined:
  - Adds a PARITY state between DATA and STOP that samples one even-parity bit.
  - Adds an output port parity_error (1 bit, reset 0).
  - A parity mismatch sets parity_error=1 and suppresses char_received; parallel_out is not updated even if the stop bit is good.
  - parity_error clears on the next start-bit detection.
  - Latency grows by CLKS_PER_BIT (171 for 16).
- When undefined: no PARITY state, no parity_error port, 8N1 only.

Decomposition:
- Package serial_pkg:
  - State enum rx_state_t {IDLE, START, DATA, STOP, PARITY}.
  - Constant FRAME_DATA_BITS=8.
  - Localparam helper for half-bit count.
- Sub-module bit_sync2: 2-FF synchroniser with async active-low reset and a reset value parameter. It is reusable by the companion transmitter.

Test Plan:
- Send 0xA5 with CLKS_PER_BIT=16 → parallel_out=8'hA5, char_received rises exactly 155 clocks after the falling edge, framing_error=0.
- Send 0x3C then 0xC3 back-to-back with no idle gap → parallel_out=8'h3C then 8'hC3. char_received drops at the second start detection and re-rises 155 clocks later.
- Send 0x55 with the stop bit forced 0 → framing_error=1, char_received=0, parallel_out keeps its prior value (8'hA5).
- Pulse serial_in low for 4 clocks (shorter than a half-bit) → FSM returns to IDLE, no flags change, busy high for ≤10 clocks.
- Assert reset_reset_n=0 during DATA bit 4 of 0xFF → all outputs read 0 immediately (asynchronously). A following clean 0x81 frame is received correctly.
- With SERIAL_RX_PARITY_EN, send 0x07 with an odd parity bit → parity_error=1, char_received=0. With a correct parity bit → parallel_out=8'h07 at 171 clocks.
